uart_frame_parser: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 20 ++
 rtl/frame_timeout_counter.sv | 31 +++
 rtl/uart_frame_parser.sv | 163 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART command framer: parser state encoding,
// default start-of-frame byte and the 8-bit wrapping checksum helper.
// Combinational helpers only; no state, no flow control.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GET_LEN     = 2'd1,
        GET_PAYLOAD = 2'd2,
        GET_CHK     = 2'd3
    } frame_state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Running checksum step: a good frame brings LEN + payload + CHK to zero.
    function automatic logic [7:0] uart_frame_chk(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte inactivity counter for the frame parser.
// Latency: expired is combinational from the count register (asserts when count == TIMEOUT-1).
// Backpressure: none; clear dominates enable, count self-clears after expiry.
// Ports: clk_100MHz/reset (async, active-high), clear, enable, expired.
module frame_timeout_counter #(
    parameter int TIMEOUT = 1_000_000,
    parameter int TO_BITS = 20
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_BITS-1:0] count_q;

    assign expired = enable && (count_q == TO_BITS'(TIMEOUT - 1));

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            // Wrap to zero on expiry so the counter never runs past TIMEOUT-1.
            count_q <= expired ? '0 : count_q + TO_BITS'(1);
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts SOF/LEN/payload/CHK command frames from the UART receiver byte stream.
// Latency: frame_valid / error pulses registered, one cycle after the deciding byte strobe.
// Backpressure: none; every rx_valid byte is consumed, back-to-back strobes allowed.
// Ports: clk_100MHz, reset (async, active-high), rx_valid/rx_byte in;
//        frame_valid/frame_len/frame_data, err_length/err_checksum/err_timeout, busy out.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int               DBITS    = 8,
    parameter int               MAX_LEN  = 4,
    parameter int               LEN_BITS = 3,
    parameter logic [DBITS-1:0] SOF      = SOF_DEFAULT,
    parameter int               TIMEOUT  = 1_000_000,
    parameter int               TO_BITS  = 20
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [DBITS-1:0]         rx_byte,
    output logic                     frame_valid,
    output logic [LEN_BITS-1:0]      frame_len,
    output logic [DBITS*MAX_LEN-1:0] frame_data,
    output logic                     err_length,
    output logic                     err_checksum,
    output logic                     err_timeout,
    output logic                     busy
);

    frame_state_t               state_q, state_d;
    logic [DBITS-1:0]           acc_q, acc_d;
    logic [LEN_BITS-1:0]        idx_q, idx_d;
    logic [LEN_BITS-1:0]        len_q, len_d;
    logic [DBITS-1:0]           shadow_q [MAX_LEN];
    logic [DBITS-1:0]           shadow_d [MAX_LEN];
    logic [LEN_BITS-1:0]        frame_len_d;
    logic [DBITS*MAX_LEN-1:0]   frame_data_d;
    logic                       frame_valid_d;
    logic                       err_length_d;
    logic                       err_checksum_d;
    logic                       err_timeout_d;
    logic                       to_clear;
    logic                       to_enable;
    logic                       to_expired;

    // Counter idles at zero outside a frame and restarts on every byte.
    assign to_clear  = rx_valid || (state_q == IDLE);
    assign to_enable = (state_q != IDLE);

    frame_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .TO_BITS (TO_BITS)
    ) u_timeout (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clear      (to_clear),
        .enable     (to_enable),
        .expired    (to_expired)
    );

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        idx_d          = idx_q;
        len_d          = len_q;
        shadow_d       = shadow_q;
        frame_len_d    = frame_len;
        frame_data_d   = frame_data;
        frame_valid_d  = 1'b0;
        err_length_d   = 1'b0;
        err_checksum_d = 1'b0;
        err_timeout_d  = 1'b0;

        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    // Non-SOF bytes between frames are line noise; drop quietly.
                    if (rx_byte == SOF) begin
                        state_d = GET_LEN;
                    end
                end
                GET_LEN: begin
                    // Full-width compare so e.g. 8'h84 is not mistaken for 4.
                    if ((rx_byte == '0) || (rx_byte > DBITS'(MAX_LEN))) begin
                        err_length_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        len_d   = rx_byte[LEN_BITS-1:0];
                        acc_d   = rx_byte;
                        idx_d   = '0;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            shadow_d[i] = '0;
                        end
                        state_d = GET_PAYLOAD;
                    end
                end
                GET_PAYLOAD: begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (idx_q == LEN_BITS'(i)) begin
                            shadow_d[i] = rx_byte;
                        end
                    end
                    acc_d = uart_frame_chk(acc_q, rx_byte);
                    if ((idx_q + LEN_BITS'(1)) == len_q) begin
                        state_d = GET_CHK;
                    end else begin
                        idx_d = idx_q + LEN_BITS'(1);
                    end
                end
                GET_CHK: begin
                    if (uart_frame_chk(acc_q, rx_byte) == '0) begin
                        // Shadow was zeroed on entry, so slots beyond len are already zero.
                        for (int i = 0; i < MAX_LEN; i++) begin
                            frame_data_d[i*DBITS +: DBITS] = shadow_q[i];
                        end
                        frame_len_d   = len_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        err_checksum_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (to_expired) begin
            // A byte on the expiry cycle takes the branch above instead.
            err_timeout_d = 1'b1;
            state_d       = IDLE;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                shadow_q[i] <= '0;
            end
            frame_len    <= '0;
            frame_data   <= '0;
            frame_valid  <= 1'b0;
            err_length   <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            shadow_q     <= shadow_d;
            frame_len    <= frame_len_d;
            frame_data   <= frame_data_d;
            frame_valid  <= frame_valid_d;
            err_length   <= err_length_d;
            err_checksum <= err_checksum_d;
            err_timeout  <= err_timeout_d;
            busy         <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames plus random streams
// checked against a frame-level reference model (event kind, payload, length, cycle).
// Inputs driven on the falling edge; outputs sampled 1 time unit after the rising edge.
module tb_uart_frame_parser;

    localparam int         MAX_LEN  = 4;
    localparam int         LEN_BITS = 3;
    localparam int         TIMEOUT  = 50;
    localparam int         TO_BITS  = 6;
    localparam logic [7:0] SOF      = 8'hA5;

    // kind: 0 frame, 1 length error, 2 checksum error, 3 timeout
    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [2:0]  len;
        int          cyc;
    } ev_t;

    logic                clk_100MHz = 1'b0;
    logic                reset;
    logic                rx_valid;
    logic [7:0]          rx_byte;
    logic                frame_valid;
    logic [LEN_BITS-1:0] frame_len;
    logic [31:0]         frame_data;
    logic                err_length;
    logic                err_checksum;
    logic                err_timeout;
    logic                busy;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int excl_err  = 0;
    int last_smp  = 0;

    ev_t        act_q[$];
    ev_t        exp_q[$];
    logic [7:0] cur[$];
    logic [31:0] mdl_data = '0;
    logic [2:0]  mdl_len  = '0;

    uart_frame_parser #(
        .DBITS    (8),
        .MAX_LEN  (MAX_LEN),
        .LEN_BITS (LEN_BITS),
        .SOF      (SOF),
        .TIMEOUT  (TIMEOUT),
        .TO_BITS  (TO_BITS)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .frame_valid  (frame_valid),
        .frame_len    (frame_len),
        .frame_data   (frame_data),
        .err_length   (err_length),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .busy         (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    // Event recorder: every pulse becomes an event stamped with the sample cycle.
    always @(posedge clk_100MHz) begin : mon
        ev_t e;
        #1;
        if ((int'(frame_valid) + int'(err_length) + int'(err_checksum) + int'(err_timeout)) > 1)
            excl_err = excl_err + 1;
        e.cyc  = cyc;
        e.data = '0;
        e.len  = '0;
        if (frame_valid) begin
            e.kind = 0; e.data = frame_data; e.len = frame_len; act_q.push_back(e);
        end
        if (err_length)   begin e.kind = 1; act_q.push_back(e); end
        if (err_checksum) begin e.kind = 2; act_q.push_back(e); end
        if (err_timeout)  begin e.kind = 3; act_q.push_back(e); end
    end

    // Frame-level reference: collect bytes from SOF, decide once LEN or the full frame is in.
    task automatic model_feed(input logic [7:0] b, input int smp);
        int          L;
        logic [7:0]  s;
        ev_t         e;
        if (cur.size() == 0) begin
            if (b == SOF) cur.push_back(b);
        end else begin
            cur.push_back(b);
            L      = int'(cur[1]);
            e.cyc  = smp;
            e.data = '0;
            e.len  = '0;
            if (cur.size() == 2) begin
                if (L == 0 || L > MAX_LEN) begin
                    e.kind = 1; exp_q.push_back(e); cur.delete();
                end
            end else if (cur.size() == L + 3) begin
                s = 8'h00;
                for (int i = 1; i < cur.size(); i++) s = s + cur[i];
                if (s == 8'h00) begin
                    for (int i = 0; i < L; i++) e.data[8*i +: 8] = cur[2+i];
                    e.kind = 0; e.len = 3'(L);
                    mdl_data = e.data; mdl_len = e.len;
                end else begin
                    e.kind = 2;
                end
                exp_q.push_back(e);
                cur.delete();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk_100MHz);
        rx_valid = 1'b1;
        rx_byte  = b;
        last_smp = cyc + 1;
        model_feed(b, cyc + 1);
        if (gap > 0) begin
            @(negedge clk_100MHz);
            rx_valid = 1'b0;
            rx_byte  = 8'($urandom);
            repeat (gap - 1) @(negedge clk_100MHz);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        repeat (3) @(negedge clk_100MHz);
        checks++; if (frame_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", frame_data); end
        checks++; if (frame_len !== 3'd0) begin errors++; $display("FAIL reset_len got %0d want 0", frame_len); end
        checks++; if ({frame_valid, err_length, err_checksum, err_timeout} !== 4'b0) begin
            errors++; $display("FAIL reset_pulses got %b want 0000", {frame_valid, err_length, err_checksum, err_timeout}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        repeat (2) @(negedge clk_100MHz);
        checks++; if ({busy, frame_data, frame_len} !== 36'h0) begin
            errors++; $display("FAIL post_reset got busy=%b data=%h len=%0d want 0", busy, frame_data, frame_len); end
    endtask

    task automatic test_good_frame;
        int a0 = act_q.size();
        send_byte(8'hA5, 1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_rise got %b want 1", busy); end
        send_byte(8'h03, 1); send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h97, 1);
        repeat (2) @(negedge clk_100MHz);
        checks++; if (act_q.size() - a0 !== 1) begin errors++; $display("FAIL good_events got %0d want 1", act_q.size() - a0); end
        if (act_q.size() > a0) begin
            checks++;
            if (act_q[a0].kind !== 0 || act_q[a0].data !== 32'h00332211 || act_q[a0].len !== 3'd3 || act_q[a0].cyc !== last_smp) begin
                errors++;
                $display("FAIL good_frame got kind=%0d data=%h len=%0d cyc=%0d want kind=0 data=00332211 len=3 cyc=%0d",
                         act_q[a0].kind, act_q[a0].data, act_q[a0].len, act_q[a0].cyc, last_smp);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_fall got %b want 0", busy); end
    endtask

    task automatic test_bad_checksum;
        int a0 = act_q.size();
        send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h10, 1); send_byte(8'h20, 1); send_byte(8'h00, 1);
        repeat (2) @(negedge clk_100MHz);
        checks++;
        if (act_q.size() - a0 !== 1 || act_q[a0].kind !== 2 || act_q[a0].cyc !== last_smp) begin
            errors++; $display("FAIL bad_chk events=%0d want 1 checksum event at cyc %0d", act_q.size() - a0, last_smp);
        end
        checks++; if (frame_data !== 32'h00332211 || frame_len !== 3'd3) begin
            errors++; $display("FAIL bad_chk_hold got data=%h len=%0d want 00332211/3", frame_data, frame_len); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_chk_busy got %b want 0", busy); end
    endtask

    task automatic test_length;
        int a0 = act_q.size();
        send_byte(8'hA5, 1); send_byte(8'h05, 1);
        send_byte(8'hA5, 1); send_byte(8'h00, 1);
        send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h7F, 1); send_byte(8'h80, 1);
        repeat (2) @(negedge clk_100MHz);
        checks++; if (act_q.size() - a0 !== 3) begin errors++; $display("FAIL len_events got %0d want 3", act_q.size() - a0); end
        if (act_q.size() - a0 >= 3) begin
            checks++; if (act_q[a0].kind !== 1 || act_q[a0+1].kind !== 1) begin
                errors++; $display("FAIL len_errs got kinds %0d,%0d want 1,1", act_q[a0].kind, act_q[a0+1].kind); end
            checks++; if (act_q[a0+2].kind !== 0) begin errors++; $display("FAIL len_next_kind got %0d want 0", act_q[a0+2].kind); end
        end
        checks++; if (frame_data !== 32'h0000007F || frame_len !== 3'd1) begin
            errors++; $display("FAIL len_next_frame got data=%h len=%0d want 0000007f/1", frame_data, frame_len); end
    endtask

    task automatic test_back_to_back;
        int a0 = act_q.size();
        send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0); send_byte(8'hA5, 0);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'hFF, 2);
        repeat (2) @(negedge clk_100MHz);
        checks++;
        if (act_q.size() - a0 !== 1 || act_q[a0].kind !== 0 || act_q[a0].cyc !== last_smp) begin
            errors++; $display("FAIL b2b_events count=%0d want one frame at cyc %0d", act_q.size() - a0, last_smp);
        end
        checks++; if (frame_data !== 32'h0 || frame_len !== 3'd1) begin
            errors++; $display("FAIL b2b_frame got data=%h len=%0d want 00000000/1", frame_data, frame_len); end
    endtask

    task automatic test_timeout;
        int a0 = act_q.size();
        int smp;
        send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h10, TIMEOUT + 5);
        smp = last_smp;
        checks++;
        if (act_q.size() - a0 !== 1 || act_q[a0].kind !== 3 || act_q[a0].cyc !== smp + TIMEOUT) begin
            errors++;
            $display("FAIL timeout_pulse count=%0d kind=%0d cyc=%0d want one timeout at cyc %0d",
                     act_q.size() - a0, (act_q.size() > a0) ? act_q[a0].kind : -1,
                     (act_q.size() > a0) ? act_q[a0].cyc : -1, smp + TIMEOUT);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
        cur.delete();
        // Second pass: next byte lands exactly on the expiry cycle.
        a0 = act_q.size();
        send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h10, TIMEOUT - 1);
        send_byte(8'h20, 1); send_byte(8'hCE, 3);
        checks++;
        if (act_q.size() - a0 !== 1 || act_q[a0].kind !== 0) begin
            errors++; $display("FAIL timeout_race count=%0d want one frame and no timeout", act_q.size() - a0);
        end
        checks++; if (frame_data !== 32'h00002010 || frame_len !== 3'd2) begin
            errors++; $display("FAIL timeout_race_frame got data=%h len=%0d want 00002010/2", frame_data, frame_len); end
    endtask

    task automatic test_reset_mid_frame;
        int a0;
        send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        @(negedge clk_100MHz);
        reset = 1'b1;
        #1;
        checks++; if ({busy, frame_valid, err_length, err_checksum, err_timeout} !== 5'b0 || frame_data !== 32'h0 || frame_len !== 3'd0) begin
            errors++; $display("FAIL midrst_outputs got busy=%b data=%h len=%0d want all zero", busy, frame_data, frame_len); end
        @(negedge clk_100MHz);
        reset = 1'b0;
        cur.delete(); mdl_data = '0; mdl_len = '0;
        a0 = act_q.size();
        send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h7F, 1); send_byte(8'h80, 2);
        checks++;
        if (act_q.size() - a0 !== 1 || frame_data !== 32'h0000007F || frame_len !== 3'd1) begin
            errors++; $display("FAIL midrst_after got events=%0d data=%h len=%0d want 1/0000007f/1", act_q.size() - a0, frame_data, frame_len);
        end
    endtask

    task automatic test_random;
        int          a0 = act_q.size();
        int          e0 = exp_q.size();
        int          n;
        logic [7:0]  L;
        logic [7:0]  sum;
        logic [7:0]  b;
        for (int f = 0; f < 60; f++) begin
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                if (b == SOF) b = 8'h3C;
                send_byte(b, $urandom_range(0, 3));
            end
            send_byte(SOF, $urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       L = 8'h00;
                1:       L = 8'h05 + 8'($urandom_range(0, 3));
                2:       L = 8'h80 + 8'($urandom_range(1, 4));
                default: L = 8'($urandom_range(1, MAX_LEN));
            endcase
            send_byte(L, $urandom_range(0, 3));
            if (L != 8'h00 && L <= MAX_LEN) begin
                sum = L;
                for (int j = 0; j < int'(L); j++) begin
                    b = 8'($urandom);
                    sum = sum + b;
                    send_byte(b, $urandom_range(0, 3));
                end
                b = 8'h00 - sum;
                if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
                send_byte(b, $urandom_range(0, 3));
            end
        end
        @(negedge clk_100MHz);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk_100MHz);
        checks++;
        if (act_q.size() - a0 !== exp_q.size() - e0) begin
            errors++; $display("FAIL rand_count got %0d want %0d", act_q.size() - a0, exp_q.size() - e0);
        end
        for (int i = 0; i < exp_q.size() - e0 && i < act_q.size() - a0; i++) begin
            checks++;
            if (act_q[a0+i].kind !== exp_q[e0+i].kind || act_q[a0+i].data !== exp_q[e0+i].data ||
                act_q[a0+i].len !== exp_q[e0+i].len || act_q[a0+i].cyc !== exp_q[e0+i].cyc) begin
                errors++;
                $display("FAIL rand_event[%0d] got kind=%0d data=%h len=%0d cyc=%0d want kind=%0d data=%h len=%0d cyc=%0d", i,
                         act_q[a0+i].kind, act_q[a0+i].data, act_q[a0+i].len, act_q[a0+i].cyc,
                         exp_q[e0+i].kind, exp_q[e0+i].data, exp_q[e0+i].len, exp_q[e0+i].cyc);
            end
        end
        checks++; if (frame_data !== mdl_data || frame_len !== mdl_len) begin
            errors++; $display("FAIL rand_hold got data=%h len=%0d want %h/%0d", frame_data, frame_len, mdl_data, mdl_len); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy got %b want 0", busy); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_checksum;
        test_length;
        test_back_to_back;
        test_timeout;
        test_reset_mid_frame;
        test_random;
        checks++;
        if (excl_err !== 0) begin errors++; $display("FAIL pulse_exclusive got %0d overlapping cycles want 0", excl_err); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
